// File: rtl/reset_synchroniser.sv
// Reset bridge: asserts the domain reset asynchronously, releases it synchronously after STAGES + MIN_ASSERT_CYCLES edges.
// Optional reset-event counter on reset_count_o when RESET_SYNC_EVENT_COUNT_EN is defined.
module reset_synchroniser #(
   parameter int INPUT_POLARITY    = 0,
   parameter int OUTPUT_POLARITY   = 1,
   parameter int STAGES            = 2,
   parameter int MIN_ASSERT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst_i,
   input  logic        async_reset_i,
   output logic        sync_reset_o
`ifdef RESET_SYNC_EVENT_COUNT_EN
   ,
   output logic [15:0] reset_count_o
`endif
);

   localparam logic IN_POL  = 1'(INPUT_POLARITY);
   localparam logic OUT_POL = 1'(OUTPUT_POLARITY);
   localparam int   CW      = (MIN_ASSERT_CYCLES > 0) ? $clog2(MIN_ASSERT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(MIN_ASSERT_CYCLES);

   if (STAGES < 2) begin : g_bad_stages
      $error("reset_synchroniser: STAGES must be at least 2");
   end

   logic              w_req;
   logic              w_r;
   logic [STAGES-1:0] r_stage = '1;
   logic [CW-1:0]     r_cnt   = CNT_LOAD;

   assign w_req = (async_reset_i == IN_POL);

   // Request acts as an asynchronous set; only the release path is clocked.
   always_ff @(posedge clk or posedge w_req) begin
      if (w_req) begin
         r_stage <= '1;
      end else if (rst_i) begin
         r_stage <= '1;
      end else begin
         r_stage <= {r_stage[STAGES-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or posedge w_req) begin
      if (w_req) begin
         r_cnt <= CNT_LOAD;
      end else if (rst_i) begin
         r_cnt <= CNT_LOAD;
      end else if (!r_stage[STAGES-1] && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CW'(1);
      end
   end

   assign w_r          = r_stage[STAGES-1] | (r_cnt != '0);
   assign sync_reset_o = w_r ? OUT_POL : ~OUT_POL;

`ifdef RESET_SYNC_EVENT_COUNT_EN
   // Previous-r starts at 1 so the power-up assertion is not counted as an event.
   logic        r_prev      = 1'b1;
   logic [15:0] r_evt_cnt   = '0;

   always_ff @(posedge clk) begin
      r_prev <= w_r;
      if (!r_prev && w_r && (r_evt_cnt != '1)) begin
         r_evt_cnt <= r_evt_cnt + 16'd1;
      end
   end

   assign reset_count_o = r_evt_cnt;
`endif

endmodule

// File: tb/tb_reset_synchroniser.sv
// Bench for reset_synchroniser: three configurations driven from one request, checked against an
// edge-count model (output asserted while requested or fewer than STAGES+MIN edges since the last request/rst).
module tb_reset_synchroniser;

   localparam int SA = 2, MA = 0;
   localparam int SB = 3, MB = 4;
   localparam int SC = 2, MC = 0;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic req = 1'b0;
   logic async_n, async_p;
   logic out_a, out_b, out_c;

   int unsigned vectors    = 0;
   int unsigned miscompares = 0;
   int nA = 0, nB = 0, nC = 0;

   assign async_n = ~req;
   assign async_p = req;

   always #5 clk = ~clk;

`ifdef RESET_SYNC_EVENT_COUNT_EN
   logic [15:0] cnt_a;
   int          evA   = 0;
   logic        prevA = 1'b1;
`endif

   reset_synchroniser #(.INPUT_POLARITY(0), .OUTPUT_POLARITY(1), .STAGES(SA), .MIN_ASSERT_CYCLES(MA)) u_a (
      .clk(clk), .rst_i(rst), .async_reset_i(async_n), .sync_reset_o(out_a)
`ifdef RESET_SYNC_EVENT_COUNT_EN
      , .reset_count_o(cnt_a)
`endif
   );

   reset_synchroniser #(.INPUT_POLARITY(0), .OUTPUT_POLARITY(1), .STAGES(SB), .MIN_ASSERT_CYCLES(MB)) u_b (
`ifdef RESET_SYNC_EVENT_COUNT_EN
      .reset_count_o(),
`endif
      .clk(clk), .rst_i(rst), .async_reset_i(async_n), .sync_reset_o(out_b)
   );

   reset_synchroniser #(.INPUT_POLARITY(1), .OUTPUT_POLARITY(0), .STAGES(SC), .MIN_ASSERT_CYCLES(MC)) u_c (
`ifdef RESET_SYNC_EVENT_COUNT_EN
      .reset_count_o(),
`endif
      .clk(clk), .rst_i(rst), .async_reset_i(async_p), .sync_reset_o(out_c)
   );

   // Reference model: edges since the last request or sampled rst_i.
   always @(posedge req) begin
      nA = 0; nB = 0; nC = 0;
   end

   always @(posedge clk) begin
`ifdef RESET_SYNC_EVENT_COUNT_EN
      begin
         logic cur;
         cur = req || (nA < SA + MA);
         if (!prevA && cur && evA < 65535) evA++;
         prevA = cur;
      end
`endif
      if (req || rst) begin
         nA = 0; nB = 0; nC = 0;
      end else begin
         if (nA < 1000) nA++;
         if (nB < 1000) nB++;
         if (nC < 1000) nC++;
      end
   end

   task automatic chk(input string tag);
      logic ea, eb, ec;
      ea = req || (nA < SA + MA);
      eb = req || (nB < SB + MB);
      ec = !(req || (nC < SC + MC));
      vectors += 3;
      assert (out_a === ea) else begin
         miscompares++;
         $error("FAIL %s/A observed=%0b expected=%0b t=%0t", tag, out_a, ea, $time);
      end
      assert (out_b === eb) else begin
         miscompares++;
         $error("FAIL %s/B observed=%0b expected=%0b t=%0t", tag, out_b, eb, $time);
      end
      assert (out_c === ec) else begin
         miscompares++;
         $error("FAIL %s/C observed=%0b expected=%0b t=%0t", tag, out_c, ec, $time);
      end
`ifdef RESET_SYNC_EVENT_COUNT_EN
      vectors += 1;
      assert (cnt_a === 16'(evA)) else begin
         miscompares++;
         $error("FAIL %s/count observed=%0d expected=%0d", tag, cnt_a, evA);
      end
`endif
   endtask

   initial begin
      // Power-up: asserted with no edge, A/C release on the 2nd edge (15 ns).
      #1  chk("powerup");
      #5  chk("edge1");
      #10 chk("edge2");
      // Request between edges: immediate assertion, release two edges later.
      #6  req = 1'b1;
      #1  chk("req_assert");
      #9  req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1 chk("req_release");
      end
      // 2 ns glitch between edges.
      #3  req = 1'b1;
      #1  chk("glitch_on");
      #1  req = 1'b0;
      #1  chk("glitch_off");
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1 chk("glitch_release");
      end
      // One-edge rst_i while idle.
      #2  rst = 1'b1;
      @(posedge clk); #1 chk("rst_edge");
      #2  rst = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1 chk("rst_release");
      end
      // Re-assert mid-release at the 5th edge: B's count restarts.
      #2  req = 1'b1;
      #2  req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1 chk("restart_pre");
      end
      #2  req = 1'b1;
      #1  chk("restart_req");
      #2  req = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1 chk("restart_post");
      end
      // rst_i and request together.
      #2  rst = 1'b1; req = 1'b1;
      @(posedge clk); #1 chk("both");
      #2  rst = 1'b0; req = 1'b0;
      // Randomised phase.
      for (int i = 0; i < 400; i++) begin
         int unsigned act;
         @(posedge clk);
         #1 chk("rand_edge");
         act = $urandom_range(0, 15);
         rst = 1'b0;
         if (req) begin
            if (act < 6) req = 1'b0;
         end else if (act == 0) begin
            req = 1'b1;
         end else if (act == 1) begin
            req = 1'b1;
            #1 chk("rand_glitch");
            req = 1'b0;
         end
         if (act == 2 || act == 3) rst = 1'b1;
         #2 chk("rand_async");
      end
      rst = 1'b0; req = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1 chk("drain");
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/reset_synchroniser.md
# reset_synchroniser

Reset bridge between an external asynchronous reset source and one clock domain. It asserts the domain reset asynchronously and releases it only synchronously, after a configurable number of `clk` rising edges. The block sits at the root of each clock domain's reset tree and feeds every synchronous-reset consumer in that domain.

## Interface
Parameters:
- `INPUT_POLARITY`, default 0: asserted level of `async_reset_i` (0 = active-low, 1 = active-high).
- `OUTPUT_POLARITY`, default 1: asserted level of `sync_reset_o`.
- `STAGES`, default 2: synchroniser depth. Must be ≥ 2; a smaller value is an elaboration error.
- `MIN_ASSERT_CYCLES`, default 0: extra `clk` cycles `sync_reset_o` stays asserted after the synchroniser releases.

Ports:
- `clk` in 1: the only clock; all logic uses its rising edge.
- `rst_i` in 1: synchronous, active-high reset. Sampled on the `clk` rising edge.
- `async_reset_i` in 1: asynchronous reset request, polarity set by `INPUT_POLARITY`. May change at any time.
- `sync_reset_o` out 1: domain reset, polarity set by `OUTPUT_POLARITY`.
- `reset_count_o` out 16: present only with `RESET_SYNC_EVENT_COUNT_EN`; count of reset assertion events.

## Operation
- Internal request: `req = (async_reset_i == INPUT_POLARITY)`.
- Chain `stage[STAGES-1:0]`, with 1 meaning asserted.
- While `req` = 1, the chain is forced to all-1 asynchronously, with no clock needed.
- Otherwise, on each `clk` rising edge:
  - if `rst_i` = 1: chain set to all-1, stretch counter loaded with `MIN_ASSERT_CYCLES`;
  - else: `stage[0]` <= 0 and `stage[k]` <= `stage[k-1]`.
- Stretch counter:
  - loaded with `MIN_ASSERT_CYCLES` while `req` = 1 (asynchronously) or while `rst_i` = 1 (synchronously);
  - decrements by 1 per edge once `stage[STAGES-1]` = 0;
  - holds at 0.
- Internal reset: `r = stage[STAGES-1] | (cnt != 0)`.
- Output: `sync_reset_o = r ? OUTPUT_POLARITY : !OUTPUT_POLARITY`. This is a direct flop or OR output with no further combinational logic on `async_reset_i`, apart from the asynchronous set.
- Power-up: chain initialised all-1 and counter initialised to `MIN_ASSERT_CYCLES`, so the output starts asserted.
- Request glitch shorter than one clock period: output still asserts and then releases through the full chain.
- `rst_i` and `req` active together: request wins; output asserted.
- Re-assertion mid-release: chain refilled immediately and the release count restarts from zero.

## Timing
- Assertion: combinational through the asynchronous set, 0 clock cycles.
- Release: `sync_reset_o` deasserts on the `STAGES`+`MIN_ASSERT_CYCLES`-th rising edge after `req` deasserts.
- `rst_i` release: the same count, taken from the first edge that samples `rst_i` = 0.
- `sync_reset_o` changes only on `clk` edges when deasserting.

## Configuration
- `RESET_SYNC_EVENT_COUNT_EN` defined:
  - adds `reset_count_o`, a register initialised to 0 at power-up and never cleared by `rst_i` or `req`;
  - a registered copy of `r` is kept, and the count increments by 1 on each edge where the copy is 0 and `r` is 1;
  - the count saturates at 0xFFFF.
- Not defined: no port and no logic.

## Test plan
- Power-up, `async_reset_i` = 1, `rst_i` = 0, defaults: `sync_reset_o` = 1, then 0 after the 2nd rising edge (15 ns with a 10 ns clock whose first edge is at 5 ns).
- `async_reset_i` low at 10 ns, high at 20 ns, defaults: `sync_reset_o` = 1 at 10 ns with no edge required, then 0 at the 35 ns edge.
- 2 ns low pulse between edges: `sync_reset_o` asserts, then releases 2 edges later; with the macro, `reset_count_o` increments by exactly 1.
- `rst_i` = 1 for one edge while idle: `sync_reset_o` = 1 from that edge, then 0 two edges after `rst_i` falls.
- `STAGES` = 3, `MIN_ASSERT_CYCLES` = 4: release lands on the 7th edge after `req` deasserts; re-asserting `req` at edge 5 restarts the count.
- `INPUT_POLARITY` = 1, `OUTPUT_POLARITY` = 0: `async_reset_i` = 1 drives `sync_reset_o` = 0 immediately, and `async_reset_i` = 0 releases it after 2 edges.
